triangle_pixel_scanner: RTL and testbench
=========================================

Name: triangle_pixel_scanner

Overview:
Upstream of the per-pixel inside test; receives one 160-bit triangle word and computes its screen-clipped bounding box. Walks the box raster-order, one pixel per accepted cycle, driving xcoord/ycoord/valid into the inside-test stage with the triangle word held alongside. Pulses tri_done after the last pixel of the box so the frame controller can issue the next triangle.

Parameters:
H_ACTIVE, 1280, visible columns; x clipped to [0, H_ACTIVE-1]
V_ACTIVE, 720, visible rows; y clipped to [0, V_ACTIVE-1]

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
tri_in  input  160  color|p1x|p1y|p2x|p2y|p3x|p3y|P|nx|ny|nz; vertices are signed 16-bit at [143:128],[127:112],[111:96],[95:80],[79:64],[63:48]
tri_valid  input  1  tri_in valid
tri_ready  output  1  scanner can accept a triangle
tri_out  output  160  latched triangle, stable from acceptance until tri_done
pix_ready  input  1  downstream accepts the pixel; tie high when the downstream cannot stall
pix_valid  output  1  xcoord_out/ycoord_out valid
xcoord_out  output  11  pixel column
ycoord_out  output  10  pixel row
pix_last  output  1  high with the final pixel of the box
tri_done  output  1  one-cycle pulse: triangle fully scanned or culled

Behaviour:
- Reset (rst==0 at posedge): state IDLE. tri_ready=0, pix_valid=0, pix_last=0, tri_done=0, xcoord_out=0, ycoord_out=0, tri_out=0. Reset mid-scan abandons the triangle; no tri_done is issued.
- States: IDLE, SETUP, SCAN.
- IDLE: tri_ready=1. A transfer occurs on tri_valid&&tri_ready; latch tri_in into tri_out and go to SETUP. tri_ready=0 in SETUP and SCAN.
- SETUP (1 cycle): compute signed xmin/xmax/ymin/ymax over the three vertices, 17-bit signed to avoid overflow.
  - Empty if xmax<0, ymax<0, xmin>H_ACTIVE-1 or ymin>V_ACTIVE-1. Empty boxes pulse tri_done and go to IDLE with no pixels emitted.
  - Otherwise clamp min to 0 and max to the active limit, register cxmin/cxmax/cymin/cymax, set x=cxmin, y=cymin, go to SCAN.
- SCAN: pix_valid=1 and pix_last=(x==cxmax && y==cymax).
  - On pix_ready with pix_last: tri_done pulses on the next cycle, pix_valid drops, state goes to IDLE.
  - On pix_ready with x==cxmax: x=cxmin, y=y+1.
  - On pix_ready otherwise: x=x+1.
  - While pix_ready=0, all pix outputs hold stable.
- Throughput: first pixel appears 2 cycles after acceptance. One pixel per cycle while pix_ready=1. Next triangle is accepted the cycle after tri_done is asserted, so the minimum gap between triangles is 3 cycles plus the box area.
- Degenerate single point (all vertices equal, on screen): exactly 1 pixel with pix_last=1.
- A vertex exactly on the limit (x=H_ACTIVE-1) is included; x=H_ACTIVE is clipped.

Optional Feature:
DEGENERATE_CULL_EN
- Defined: in SETUP, a triangle with p1x==p2x==p3x or p1y==p2y==p3y is treated as empty: tri_done pulses and no pixels are emitted.
- Undefined: such triangles are scanned normally. The downstream inside test rejects vertical lines itself, but horizontal lines still cost box-area cycles.

Decomposition:
- rasterizer_pkg: H_ACTIVE/V_ACTIVE defaults, triangle field bit offsets (P1X_MSB etc.), vertex coordinate typedef (signed 16), scanner state enum.
- One sub-module, bbox_clip: combinational min/max/clamp/empty detect, reused by a future tile-binning stage.

Test Plan:
- Tri (10,20),(13,20),(10,22), pix_ready=1 -> 12 pixels (10..13 × 20..22) raster order; pix_last on (13,22); tri_done the next cycle; first pix_valid 2 cycles after acceptance.
- Tri (-5,-5),(2,-3),(-1,1) -> clipped box x0..2, y0..1, 6 pixels starting (0,0).
- Tri (1300,10),(1400,20),(1350,30) with H_ACTIVE=1280 -> 0 pixels, tri_done 2 cycles after acceptance; tri_ready high the following cycle.
- Box 3×1 at (5,5) with pix_ready toggling 1,0,0,1,1 -> outputs (5,5),(6,5),(6,5),(6,5),(7,5); no pixel is skipped or duplicated on acceptance.
- Assert rst=0 after the 4th pixel of a 16-pixel box -> next cycle pix_valid=0 and tri_ready=0; after release tri_ready=1 and a new triangle scans from its own xmin/ymin.
- Tri (7,3),(7,9),(7,5): with DEGENERATE_CULL_EN -> 0 pixels, tri_done; without it -> 7 pixels, x=7, y=3..9.

Source files
------------

// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the triangle rasterizer front end:
// screen limits, triangle word field offsets, vertex types and the scanner states.
package rasterizer_pkg;

  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;

  localparam int TRI_W = 160;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int VTX_W = 16;
  localparam int EXT_W = 17;

  // Triangle word layout: color|p1x|p1y|p2x|p2y|p3x|p3y|P|nx|ny|nz
  localparam int COLOR_MSB = 159;
  localparam int COLOR_LSB = 144;
  localparam int P1X_MSB   = 143;
  localparam int P1X_LSB   = 128;
  localparam int P1Y_MSB   = 127;
  localparam int P1Y_LSB   = 112;
  localparam int P2X_MSB   = 111;
  localparam int P2X_LSB   = 96;
  localparam int P2Y_MSB   = 95;
  localparam int P2Y_LSB   = 80;
  localparam int P3X_MSB   = 79;
  localparam int P3X_LSB   = 64;
  localparam int P3Y_MSB   = 63;
  localparam int P3Y_LSB   = 48;

  typedef logic signed [VTX_W-1:0] vertex_t;
  typedef logic signed [EXT_W-1:0] coord_ext_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_e;

  function automatic vertex_t vtx_field(input logic [TRI_W-1:0] word, input int lsb);
    return vertex_t'(word[lsb +: VTX_W]);
  endfunction

  function automatic vertex_t min3(input vertex_t a, input vertex_t b, input vertex_t c);
    vertex_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic vertex_t max3(input vertex_t a, input vertex_t b, input vertex_t c);
    vertex_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/triangle_pixel_scanner_bbox_clip.sv
// bbox_clip: combinational bounding box of three signed vertices, clamped to the
// visible screen, with an empty flag when the box lies entirely off screen.
module bbox_clip
  import rasterizer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  vertex_t        p1x_i,
  input  vertex_t        p1y_i,
  input  vertex_t        p2x_i,
  input  vertex_t        p2y_i,
  input  vertex_t        p3x_i,
  input  vertex_t        p3y_i,
  output logic [X_W-1:0] cxmin_o,
  output logic [X_W-1:0] cxmax_o,
  output logic [Y_W-1:0] cymin_o,
  output logic [Y_W-1:0] cymax_o,
  output logic           empty_o
);

  localparam coord_ext_t XLIM = coord_ext_t'(H_ACTIVE - 1);
  localparam coord_ext_t YLIM = coord_ext_t'(V_ACTIVE - 1);
  localparam logic [X_W-1:0] XLIM_U = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] YLIM_U = Y_W'(V_ACTIVE - 1);

  coord_ext_t xmin_s;
  coord_ext_t xmax_s;
  coord_ext_t ymin_s;
  coord_ext_t ymax_s;

  // Widen to 17 bits so the limit comparisons never wrap.
  assign xmin_s = coord_ext_t'(min3(p1x_i, p2x_i, p3x_i));
  assign xmax_s = coord_ext_t'(max3(p1x_i, p2x_i, p3x_i));
  assign ymin_s = coord_ext_t'(min3(p1y_i, p2y_i, p3y_i));
  assign ymax_s = coord_ext_t'(max3(p1y_i, p2y_i, p3y_i));

  // Off-screen detection and clamping of each edge to the visible area.
  always_comb begin
    empty_o = (xmax_s < 17'sd0) || (ymax_s < 17'sd0) || (xmin_s > XLIM) || (ymin_s > YLIM);
    cxmin_o = (xmin_s < 17'sd0) ? {X_W{1'b0}} : xmin_s[X_W-1:0];
    cymin_o = (ymin_s < 17'sd0) ? {Y_W{1'b0}} : ymin_s[Y_W-1:0];
    cxmax_o = (xmax_s > XLIM)   ? XLIM_U      : xmax_s[X_W-1:0];
    cymax_o = (ymax_s > YLIM)   ? YLIM_U      : ymax_s[Y_W-1:0];
  end

endmodule

// File: rtl/triangle_pixel_scanner.sv
// Walks the screen-clipped bounding box of one triangle in raster order, one pixel per
// accepted cycle. Optional DEGENERATE_CULL_EN drops triangles whose vertices share an x or a y.
module triangle_pixel_scanner
  import rasterizer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TRI_W-1:0] tri_in,
  input  logic             tri_valid,
  output logic             tri_ready,
  output logic [TRI_W-1:0] tri_out,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [X_W-1:0]   xcoord_out,
  output logic [Y_W-1:0]   ycoord_out,
  output logic             pix_last,
  output logic             tri_done
);

  scan_state_e      state_q, state_d;
  logic [TRI_W-1:0] tri_q, tri_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [X_W-1:0]   cxmin_q, cxmin_d;
  logic [X_W-1:0]   cxmax_q, cxmax_d;
  logic [Y_W-1:0]   cymax_q, cymax_d;
  logic             pix_valid_q, pix_valid_d;
  logic             pix_last_q, pix_last_d;
  logic             tri_done_q, tri_done_d;
  logic             tri_ready_q, tri_ready_d;

  vertex_t          p1x_s, p1y_s, p2x_s, p2y_s, p3x_s, p3y_s;
  logic [X_W-1:0]   bb_xmin_s, bb_xmax_s;
  logic [Y_W-1:0]   bb_ymin_s, bb_ymax_s;
  logic             empty_s;
  logic             cull_s;
  logic             accept_s;

  assign p1x_s = vtx_field(tri_q, P1X_LSB);
  assign p1y_s = vtx_field(tri_q, P1Y_LSB);
  assign p2x_s = vtx_field(tri_q, P2X_LSB);
  assign p2y_s = vtx_field(tri_q, P2Y_LSB);
  assign p3x_s = vtx_field(tri_q, P3X_LSB);
  assign p3y_s = vtx_field(tri_q, P3Y_LSB);

  bbox_clip #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_bbox_clip (
    .p1x_i   (p1x_s),
    .p1y_i   (p1y_s),
    .p2x_i   (p2x_s),
    .p2y_i   (p2y_s),
    .p3x_i   (p3x_s),
    .p3y_i   (p3y_s),
    .cxmin_o (bb_xmin_s),
    .cxmax_o (bb_xmax_s),
    .cymin_o (bb_ymin_s),
    .cymax_o (bb_ymax_s),
    .empty_o (empty_s)
  );

`ifdef DEGENERATE_CULL_EN
  logic degen_s;
  assign degen_s = ((p1x_s == p2x_s) && (p2x_s == p3x_s)) ||
                   ((p1y_s == p2y_s) && (p2y_s == p3y_s));
  assign cull_s  = empty_s || degen_s;
`else
  assign cull_s  = empty_s;
`endif

  assign accept_s = (state_q == ST_IDLE) && tri_ready_q && tri_valid;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tri_q       <= {TRI_W{1'b0}};
      x_q         <= {X_W{1'b0}};
      y_q         <= {Y_W{1'b0}};
      cxmin_q     <= {X_W{1'b0}};
      cxmax_q     <= {X_W{1'b0}};
      cymax_q     <= {Y_W{1'b0}};
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      tri_done_q  <= 1'b0;
      tri_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tri_q       <= tri_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cxmin_q     <= cxmin_d;
      cxmax_q     <= cxmax_d;
      cymax_q     <= cymax_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      tri_done_q  <= tri_done_d;
      tri_ready_q <= tri_ready_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_SETUP;
        else          state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (cull_s) state_d = ST_IDLE;
        else        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (pix_ready && pix_last_q) state_d = ST_IDLE;
        else                         state_d = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    tri_d      = tri_q;
    x_d        = x_q;
    y_d        = y_q;
    cxmin_d    = cxmin_q;
    cxmax_d    = cxmax_q;
    cymax_d    = cymax_q;
    tri_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) tri_d = tri_in;
        else          tri_d = tri_q;
      end
      ST_SETUP: begin
        if (cull_s) begin
          tri_done_d = 1'b1;
        end else begin
          cxmin_d = bb_xmin_s;
          cxmax_d = bb_xmax_s;
          cymax_d = bb_ymax_s;
          x_d     = bb_xmin_s;
          y_d     = bb_ymin_s;
        end
      end
      ST_SCAN: begin
        if (!pix_ready) begin
          x_d = x_q;
        end else if (pix_last_q) begin
          tri_done_d = 1'b1;
        end else if (x_q == cxmax_q) begin
          x_d = cxmin_q;
          y_d = y_q + 10'd1;
        end else begin
          x_d = x_q + 11'd1;
        end
      end
      default: tri_done_d = 1'b0;
    endcase
    // Outputs are registered, so they are derived from the values about to be loaded.
    pix_valid_d = (state_d == ST_SCAN);
    pix_last_d  = (state_d == ST_SCAN) && (x_d == cxmax_d) && (y_d == cymax_d);
    tri_ready_d = (state_d == ST_IDLE) && !tri_done_d;
  end

  assign tri_ready  = tri_ready_q;
  assign tri_out    = tri_q;
  assign pix_valid  = pix_valid_q;
  assign xcoord_out = x_q;
  assign ycoord_out = y_q;
  assign pix_last   = pix_last_q;
  assign tri_done   = tri_done_q;

endmodule

// File: tb/tb_triangle_pixel_scanner.sv
// Table-driven bench for triangle_pixel_scanner with a pixel scoreboard queue.
module tb_triangle_pixel_scanner;

  logic         clk;
  logic         rst;
  logic [159:0] tri_in;
  logic         tri_valid;
  logic         tri_ready;
  logic [159:0] tri_out;
  logic         pix_ready;
  logic         pix_valid;
  logic [10:0]  xcoord_out;
  logic [9:0]   ycoord_out;
  logic         pix_last;
  logic         tri_done;

  triangle_pixel_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .tri_in     (tri_in),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_out    (tri_out),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .xcoord_out (xcoord_out),
    .ycoord_out (ycoord_out),
    .pix_last   (pix_last),
    .tri_done   (tri_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p1x, p1y, p2x, p2y, p3x, p3y;
    int xmin, xmax, ymin, ymax;
    bit empty;
    int mode;  // 0: pix_ready always 1, 1: pattern 1,0,0,1,1, 2: random
  } vec_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        last;
  } pix_t;

  vec_t vecs[10];
  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic set_vec(input int i, input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int x0, input int x1, input int y0,
                         input int y1, input bit e, input int m);
    vecs[i].p1x = ax; vecs[i].p1y = ay;
    vecs[i].p2x = bx; vecs[i].p2y = by;
    vecs[i].p3x = cx; vecs[i].p3y = cy;
    vecs[i].xmin = x0; vecs[i].xmax = x1;
    vecs[i].ymin = y0; vecs[i].ymax = y1;
    vecs[i].empty = e;
    vecs[i].mode = m;
  endtask

  function automatic logic [159:0] make_word(input vec_t v);
    logic [159:0] w;
    w = 160'd0;
    w[159:144] = 16'hC0DE;
    w[143:128] = v.p1x[15:0];
    w[127:112] = v.p1y[15:0];
    w[111:96]  = v.p2x[15:0];
    w[95:80]   = v.p2y[15:0];
    w[79:64]   = v.p3x[15:0];
    w[63:48]   = v.p3y[15:0];
    w[47:0]    = 48'h1234_5678_9ABC;
    return w;
  endfunction

  task automatic run_tri(input int idx);
    vec_t v;
    logic [159:0] w;
    pix_t p;
    pix_t e;
    int guard;
    int cyc;
    int ri;
    int last_acc;
    bit done;
    bit pat[5];
    v = vecs[idx];
    w = make_word(v);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    exp_q.delete();
    pix_ready = 1'b1;
    guard = 0;
    while (!tri_ready && guard < 20) begin
      step();
      guard++;
    end
    check($sformatf("tri_ready_idle[%0d]", idx), 160'(tri_ready), 160'd1);
    if (!v.empty) begin
      for (int yy = v.ymin; yy <= v.ymax; yy++) begin
        for (int xx = v.xmin; xx <= v.xmax; xx++) begin
          p.x = 11'(xx);
          p.y = 10'(yy);
          p.last = (xx == v.xmax) && (yy == v.ymax);
          exp_q.push_back(p);
        end
      end
    end
    tri_in = w;
    tri_valid = 1'b1;
    step();
    tri_valid = 1'b0;
    tri_in = 160'd0;
    check($sformatf("tri_ready_setup[%0d]", idx), 160'(tri_ready), 160'd0);
    check($sformatf("tri_out[%0d]", idx), tri_out, w);
    step();
    check($sformatf("first_valid[%0d]", idx), 160'(pix_valid), 160'(!v.empty));
    check($sformatf("done_at_2[%0d]", idx), 160'(tri_done), 160'(v.empty));
    if (v.empty) begin
      step();
      check($sformatf("ready_after_cull[%0d]", idx), 160'(tri_ready), 160'd1);
      check($sformatf("done_pulse_cull[%0d]", idx), 160'(tri_done), 160'd0);
      return;
    end
    done = 1'b0;
    cyc = 0;
    ri = 0;
    last_acc = -10;
    while (!done && cyc < 2000) begin
      if (tri_done) begin
        done = 1'b1;
        check($sformatf("pix_left[%0d]", idx), 160'(exp_q.size()), 160'd0);
        check($sformatf("valid_drop[%0d]", idx), 160'(pix_valid), 160'd0);
        check($sformatf("ready_on_done[%0d]", idx), 160'(tri_ready), 160'd0);
        check($sformatf("done_timing[%0d]", idx), 160'(last_acc), 160'(cyc - 1));
      end else begin
        check($sformatf("scan_valid[%0d]", idx), 160'(pix_valid), 160'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pixel[%0d]: got (%0d,%0d) expected none", idx, xcoord_out, ycoord_out);
        end else begin
          e = exp_q[0];
          check($sformatf("pix_x[%0d]", idx), 160'(xcoord_out), 160'(e.x));
          check($sformatf("pix_y[%0d]", idx), 160'(ycoord_out), 160'(e.y));
          check($sformatf("pix_last[%0d]", idx), 160'(pix_last), 160'(e.last));
        end
        if (v.mode == 1) pix_ready = pat[ri % 5];
        else if (v.mode == 2) pix_ready = 1'($urandom_range(0, 1));
        else pix_ready = 1'b1;
        ri++;
        if (pix_ready && pix_valid) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          last_acc = cyc;
        end
      end
      step();
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL scan_timeout[%0d]: got no tri_done expected tri_done within 2000 cycles", idx);
    end
    pix_ready = 1'b1;
    check($sformatf("ready_after_done[%0d]", idx), 160'(tri_ready), 160'd1);
    check($sformatf("done_one_cycle[%0d]", idx), 160'(tri_done), 160'd0);
  endtask

  initial begin
    rst = 1'b0;
    tri_in = 160'd0;
    tri_valid = 1'b0;
    pix_ready = 1'b1;

    set_vec(0, 10, 20, 13, 20, 10, 22, 10, 13, 20, 22, 1'b0, 0);
    set_vec(1, -5, -5, 2, -3, -1, 1, 0, 2, 0, 1, 1'b0, 0);
    set_vec(2, 1300, 10, 1400, 20, 1350, 30, 0, 0, 0, 0, 1'b1, 0);
    set_vec(3, 5, 5, 7, 5, 6, 5, 5, 7, 5, 5, 1'b0, 1);
`ifdef DEGENERATE_CULL_EN
    set_vec(4, 7, 3, 7, 9, 7, 5, 0, 0, 0, 0, 1'b1, 0);
`else
    set_vec(4, 7, 3, 7, 9, 7, 5, 7, 7, 3, 9, 1'b0, 0);
`endif
`ifdef DEGENERATE_CULL_EN
    set_vec(5, 640, 360, 640, 360, 640, 360, 0, 0, 0, 0, 1'b1, 0);
`else
    set_vec(5, 640, 360, 640, 360, 640, 360, 640, 640, 360, 360, 1'b0, 0);
`endif
    set_vec(6, 1279, 719, 1280, 718, 1277, 730, 1277, 1279, 718, 719, 1'b0, 0);
    set_vec(7, -10, -10, -1, 5, -3, -2, 0, 0, 0, 0, 1'b1, 0);
    set_vec(8, 20, 30, 24, 31, 22, 33, 20, 24, 30, 33, 1'b0, 2);
    set_vec(9, 0, 720, 5, 800, 3, 721, 0, 0, 0, 0, 1'b1, 0);

    step();
    step();
    check("rst_tri_ready", 160'(tri_ready), 160'd0);
    check("rst_pix_valid", 160'(pix_valid), 160'd0);
    check("rst_pix_last", 160'(pix_last), 160'd0);
    check("rst_tri_done", 160'(tri_done), 160'd0);
    check("rst_xcoord", 160'(xcoord_out), 160'd0);
    check("rst_ycoord", 160'(ycoord_out), 160'd0);
    check("rst_tri_out", tri_out, 160'd0);
    rst = 1'b1;
    step();
    check("ready_after_rst", 160'(tri_ready), 160'd1);

    for (int i = 0; i < 10; i++) run_tri(i);

    // Reset in the middle of a 4x4 box abandons it without tri_done.
    pix_ready = 1'b1;
    tri_in = make_word('{p1x: 100, p1y: 200, p2x: 103, p2y: 200, p3x: 100, p3y: 203,
                         xmin: 0, xmax: 0, ymin: 0, ymax: 0, empty: 1'b0, mode: 0});
    tri_valid = 1'b1;
    step();
    tri_valid = 1'b0;
    tri_in = 160'd0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_px", 160'(xcoord_out), 160'(100 + i));
      check("mid_rst_py", 160'(ycoord_out), 160'd200);
      check("mid_rst_valid", 160'(pix_valid), 160'd1);
      step();
    end
    rst = 1'b0;
    step();
    check("mid_rst_valid_low", 160'(pix_valid), 160'd0);
    check("mid_rst_ready_low", 160'(tri_ready), 160'd0);
    check("mid_rst_no_done", 160'(tri_done), 160'd0);
    rst = 1'b1;
    step();
    check("post_rst_ready", 160'(tri_ready), 160'd1);
    check("post_rst_no_done", 160'(tri_done), 160'd0);
    run_tri(0);
    run_tri(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
